instruction_encoder: RTL and testbench

Builds 32-bit calculator instruction words from a stream of keypad key codes. It is the producer end of the instruction format consumed by the instruction decoder. Decimal digits accumulate into operand A, then an operator key, then operand B. An Enter key packs the fields and presents the word on a valid/ready handshake. The block sits between the keypad scanner and the instruction decoder/control logic.

---
 rtl/instruction_encoder_pkg.sv | 23 ++
 rtl/instruction_encoder.sv | 128 ++++++++++++
 tb/tb_instruction_encoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared field widths, instruction word layout and entry states for the keypad encoder.
package instruction_encoder_pkg;

    localparam int unsigned A_W     = 15;
    localparam int unsigned B_W     = 14;
    localparam int unsigned F_W     = 3;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DISP_W  = 16;

    // Decoder-facing word: {immB, immA, funct}
    typedef struct packed {
        logic [B_W-1:0] imm_b;
        logic [A_W-1:0] imm_a;
        logic [F_W-1:0] funct;
    } instr_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        HOLD    = 2'd2
    } entry_t;

endpackage

// File: rtl/instruction_encoder.sv
// Keypad-to-instruction encoder: accumulates decimal operands around an operator
// key and offers the packed word on a valid/ready handshake once Enter is pressed.
module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic                  key_ready,
    input  logic                  clr,
    output logic [INSTR_W-1:0]    instruction,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [1:0]            entry_state,
    output logic [DISP_W-1:0]     display_value,
    output logic                  overflow
);

    // 32767*10+9 fits in 19 bits; one spare bit keeps the compare unsigned-safe
    localparam int unsigned PROD_W = 20;
    localparam int unsigned A_MAX  = (1 << A_W) - 1;
    localparam int unsigned B_MAX  = (1 << B_W) - 1;

    entry_t          state, state_nxt;
    logic [A_W-1:0]  imm_a, imm_a_nxt;
    logic [B_W-1:0]  imm_b, imm_b_nxt;
    logic [F_W-1:0]  funct, funct_nxt;
    logic            ovf, ovf_nxt;

    logic [PROD_W-1:0] acc_a_c;
    logic [PROD_W-1:0] acc_b_c;
    logic              is_digit_c;
    logic              is_oper_c;
    logic              is_enter_c;
    instr_t            word_c;

    // Operand accumulation candidates and key classification
    always_comb begin
        acc_a_c    = PROD_W'(imm_a) * PROD_W'(10) + PROD_W'(key_code);
        acc_b_c    = PROD_W'(imm_b) * PROD_W'(10) + PROD_W'(key_code);
        is_digit_c = (key_code <= 4'd9);
        is_enter_c = (key_code == 4'hF);
        is_oper_c  = !is_digit_c && !is_enter_c;
    end

    // Next-state and register update decisions
    always_comb begin
        state_nxt = state;
        imm_a_nxt = imm_a;
        imm_b_nxt = imm_b;
        funct_nxt = funct;
        ovf_nxt   = ovf;

        if (state == HOLD) begin
            // Transfer or abandon both end in a cleared ENTER_A
            if (instr_ready || clr) begin
                state_nxt = ENTER_A;
                imm_a_nxt = '0;
                imm_b_nxt = '0;
                funct_nxt = '0;
                ovf_nxt   = 1'b0;
            end
        end else if (clr) begin
            // Clear wins over a same-cycle key, which is dropped
            state_nxt = ENTER_A;
            imm_a_nxt = '0;
            imm_b_nxt = '0;
            funct_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (key_valid) begin
            if (is_digit_c) begin
                if (state == ENTER_A) begin
                    if (acc_a_c > PROD_W'(A_MAX)) begin
                        imm_a_nxt = A_W'(A_MAX);
                        ovf_nxt   = 1'b1;
                    end else begin
                        imm_a_nxt = A_W'(acc_a_c);
                    end
                end else begin
                    if (acc_b_c > PROD_W'(B_MAX)) begin
                        imm_b_nxt = B_W'(B_MAX);
                        ovf_nxt   = 1'b1;
                    end else begin
                        imm_b_nxt = B_W'(acc_b_c);
                    end
                end
            end else if (is_oper_c) begin
                funct_nxt = F_W'(key_code - 4'hA);
                state_nxt = ENTER_B;
            end else if (is_enter_c && state == ENTER_B) begin
                state_nxt = HOLD;
            end
        end
    end

    // State and operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ENTER_A;
            imm_a <= '0;
            imm_b <= '0;
            funct <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            imm_a <= imm_a_nxt;
            imm_b <= imm_b_nxt;
            funct <= funct_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Outputs are direct decodes of the registers above
    always_comb begin
        word_c.imm_b = imm_b;
        word_c.imm_a = imm_a;
        word_c.funct = funct;
    end

    assign instruction   = word_c;
    assign key_ready     = (state != HOLD);
    assign instr_valid   = (state == HOLD);
    assign entry_state   = state;
    assign overflow      = ovf;
    assign display_value = (state == ENTER_B) ? DISP_W'(imm_b) : DISP_W'(imm_a);

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench: directed keypad sequences plus random traffic against a calculator-level model.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        clr;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  entry_state;
    logic [15:0] display_value;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    // Model: what a calculator user would see
    int m_mode = 0;   // 0 typing first number, 1 typing second, 2 waiting for pickup
    int m_a    = 0;
    int m_b    = 0;
    int m_op   = 0;
    int m_ovf  = 0;
    int m_xfers   = 0;
    int dut_xfers = 0;

    instruction_encoder dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .clr          (clr),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .entry_state  (entry_state),
        .display_value(display_value),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int append_digit(input int cur, input int d, input int max, inout int ov);
        int v;
        v = cur * 10 + d;
        if (v > max) begin
            ov = 1;
            return max;
        end
        return v;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_a = 0; m_b = 0; m_op = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit c, input bit ir, input bit rs);
        if (rs) begin
            model_clear();
        end else if (m_mode == 2) begin
            if (ir) begin
                m_xfers++;
                model_clear();
            end else if (c) begin
                model_clear();
            end
        end else if (c) begin
            model_clear();
        end else if (kv) begin
            if (kc < 10) begin
                if (m_mode == 0) m_a = append_digit(m_a, kc, 32767, m_ovf);
                else             m_b = append_digit(m_b, kc, 16383, m_ovf);
            end else if (kc < 15) begin
                m_op   = kc - 10;
                m_mode = 1;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end
        end
    endtask

    // One clock: drive inputs, advance model, compare every output after the edge
    task automatic cyc(input bit kv, input int kc, input bit c, input bit ir, input bit rs);
        int exp_word;
        key_valid   = kv;
        key_code    = 4'(kc);
        clr         = c;
        instr_ready = ir;
        reset       = rs;
        #1;
        if (instr_valid && ir && !rs) dut_xfers++;
        @(posedge clk);
        model_step(kv, kc, c, ir, rs);
        #1;
        exp_word = (m_b << 18) | (m_a << 3) | m_op;
        chk("instruction", instruction, 32'(exp_word));
        chk("instr_valid", 32'(instr_valid), 32'(m_mode == 2));
        chk("key_ready", 32'(key_ready), 32'(m_mode != 2));
        chk("entry_state", 32'(entry_state), 32'(m_mode));
        chk("display", 32'(display_value), 32'(m_mode == 1 ? m_b : m_a));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("xfer_count", 32'(dut_xfers), 32'(m_xfers));
        key_valid = 1'b0;
        clr       = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic press(input int kc);
        cyc(1'b1, kc, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int seq_basic [7] = '{1, 2, 3, 10, 4, 5, 15};
        int seq_sat   [8] = '{9, 9, 9, 9, 9, 12, 7, 15};
        int x0;
        int kc;

        key_valid = 0; key_code = 0; clr = 0; instr_ready = 0; reset = 1;
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("reset_instr", instruction, 32'h0);
        chk("reset_kready", 32'(key_ready), 32'd1);

        // Basic entry
        foreach (seq_basic[i]) press(seq_basic[i]);
        chk("basic_word", instruction, 32'h00B403D8);
        chk("basic_valid", 32'(instr_valid), 32'd1);
        x0 = dut_xfers;
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("basic_one_xfer", 32'(dut_xfers - x0), 32'd1);
        chk("basic_disp0", 32'(display_value), 32'd0);

        // Saturation
        for (int i = 0; i < 4; i++) press(seq_sat[i]);
        chk("sat_9999", 32'(display_value), 32'd9999);
        for (int i = 4; i < 8; i++) begin
            press(seq_sat[i]);
            if (i == 4) chk("sat_32767", 32'(display_value), 32'd32767);
        end
        chk("sat_word", instruction, 32'h001FFFFA);
        chk("sat_ovf", 32'(overflow), 32'd1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk("sat_ovf_clr", 32'(overflow), 32'd0);

        // Backpressure with a held digit
        foreach (seq_basic[i]) press(seq_basic[i]);
        x0 = dut_xfers;
        for (int i = 0; i < 5; i++) cyc(1'b1, 3, 1'b0, 1'b0, 1'b0);
        chk("bp_word_held", instruction, 32'h00B403D8);
        chk("bp_no_xfer", 32'(dut_xfers - x0), 32'd0);
        cyc(1'b1, 3, 1'b0, 1'b1, 1'b0);
        chk("bp_one_xfer", 32'(dut_xfers - x0), 32'd1);
        chk("bp_imma0", 32'(display_value), 32'd0);

        // Entry edge cases
        press(15);
        chk("enter_in_a", 32'(entry_state), 32'd0);
        press(6); press(10); press(14);
        chk("funct_replace", 32'(instruction[2:0]), 32'd4);
        press(8); press(1);
        chk("b_keeps_a", 32'(instruction[17:3]), 32'd6);

        // clr with a digit in ENTER_B
        cyc(1'b1, 5, 1'b1, 1'b0, 1'b0);
        chk("clr_state", 32'(entry_state), 32'd0);
        chk("clr_word", instruction, 32'h0);

        // clr in HOLD with ready
        foreach (seq_basic[i]) press(seq_basic[i]);
        x0 = dut_xfers;
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0);
        chk("clr_hold_xfer", 32'(dut_xfers - x0), 32'd1);

        // reset in HOLD
        foreach (seq_basic[i]) press(seq_basic[i]);
        x0 = dut_xfers;
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);
        chk("rst_hold_noxfer", 32'(dut_xfers - x0), 32'd0);
        chk("rst_hold_valid", 32'(instr_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            kc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            cyc(($urandom_range(0, 9) < 7), kc, ($urandom_range(0, 99) < 3),
                ($urandom_range(0, 9) < 4), ($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
